// File: rtl/moving_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filt_pkg
// Purpose  : Shared definitions for the moving_interp linear upsampler:
//            accumulator width helper, FSM state type and the sign/zero
//            extension function used to widen samples into the datapath.
// Contents : EXT_MAX_W / EXT_MAX_AW - widest sample / accumulator supported
//            state_t               - {IDLE, RUN}
//            aw_of()               - accumulator width for (WIDTH, SHIFT)
//            ext()                 - sign- or zero-extension of a sample
// Revision : 1.0 - initial release
// ============================================================================
package filt_pkg;

   // Samples up to 64 bits and SHIFT up to 8 are supported by ext().
   localparam int EXT_MAX_W  = 64;
   localparam int EXT_MAX_AW = EXT_MAX_W + 8 + 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Two guard bits above WIDTH+SHIFT: one for the step sign, one so the
   // unsigned ramp never reaches the sign position of the accumulator.
   function automatic int aw_of(input int width, input int shift);
      return width + shift + 2;
   endfunction

   // Extend the low 'width' bits of x to EXT_MAX_AW bits. The caller
   // truncates the result to its own accumulator width.
   function automatic logic [EXT_MAX_AW-1:0] ext(
      input logic [EXT_MAX_W-1:0] x,
      input int                   width,
      input logic                 is_signed
   );
      logic [EXT_MAX_AW-1:0] r;
      logic                  fill;
      fill = 1'b0;
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (is_signed && (i == width - 1)) begin
            fill = x[i];
         end
      end
      r = {EXT_MAX_AW{fill}};
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (i < width) begin
            r[i] = x[i];
         end
      end
      return r;
   endfunction

endpackage : filt_pkg
`default_nettype wire

// File: rtl/moving_interp_if.sv
`default_nettype none
// ============================================================================
// Module   : moving_interp_if
// Purpose  : Sample-stream bundle for moving_interp: an input ready/valid
//            channel and an output ready/valid channel.
// Ports    : idata/ivalid/iready - input samples into the upsampler
//            odata/ovalid/oready - interpolated samples out of it
// Modports : slave  - the upsampler itself
//            master - the surrounding logic (source and sink)
// Revision : 1.0 - initial release
// ============================================================================
interface moving_interp_if
   import filt_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] idata;
   logic             ivalid;
   logic             iready;
   logic [WIDTH-1:0] odata;
   logic             ovalid;
   logic             oready;

   modport master (
      output idata, ivalid, oready,
      input  iready, odata, ovalid
   );

   modport slave (
      input  idata, ivalid, oready,
      output iready, odata, ovalid
   );
endinterface : moving_interp_if
`default_nettype wire

// File: rtl/interp_ramp_acc.sv
`default_nettype none
// ============================================================================
// Module   : interp_ramp_acc
// Purpose  : Ramp datapath of the linear upsampler. On load it starts a new
//            ramp from ext_prev towards ext_new; on advance it adds one step.
//            odata is the accumulator scaled back down by 2^SHIFT.
// Ports    : clock, reset    - clock, asynchronous active-low reset
//            load, advance   - start a ramp / take the next ramp point
//            ext_new         - extended new sample
//            ext_prev        - extended previous sample (ramp origin)
//            odata           - current ramp point, WIDTH bits
//            k_last          - current point is the R-th (equals the sample)
// Revision : 1.0 - initial release
// ============================================================================
module interp_ramp_acc
   import filt_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SHIFT  = 4,
   parameter int SIGNED = 1,
   parameter int AW     = WIDTH + SHIFT + 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [AW-1:0]    ext_new,
   input  logic [AW-1:0]    ext_prev,
   output logic [WIDTH-1:0] odata,
   output logic             k_last
);

   localparam int KW = SHIFT + 1;
   localparam logic [KW-1:0] C_RATIO = {1'b1, {SHIFT{1'b0}}};

   logic [AW-1:0] r_acc;
   logic [AW-1:0] r_step;
   logic [KW-1:0] r_k;
   logic [AW-1:0] w_step_new;
   logic [AW-1:0] w_acc_new;

   // The first ramp point is already one step past the origin, so after R
   // points the accumulator lands exactly on ext_new << SHIFT.
   assign w_step_new = ext_new - ext_prev;
   assign w_acc_new  = (ext_prev << SHIFT) + w_step_new;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_acc  <= '0;
         r_step <= '0;
         r_k    <= '0;
      end else if (load) begin
         r_acc  <= w_acc_new;
         r_step <= w_step_new;
         r_k    <= KW'(1);
      end else if (advance) begin
         r_acc  <= r_acc + r_step;
         r_k    <= r_k + KW'(1);
      end
   end

   assign k_last = (r_k == C_RATIO);

   // Floor rounding: arithmetic shift for two's-complement samples, logical
   // shift for unsigned ones (the unsigned accumulator never goes negative).
   generate
      if (SIGNED != 0) begin : g_arith_shift
         assign odata = WIDTH'($signed(r_acc) >>> SHIFT);
      end else begin : g_logic_shift
         assign odata = WIDTH'(r_acc >> SHIFT);
      end
   endgenerate

endmodule : interp_ramp_acc
`default_nettype wire

// File: rtl/moving_interp.sv
`default_nettype none
// ============================================================================
// Module   : moving_interp
// Purpose  : Linear-interpolating upsampler by R = 2^SHIFT. Every accepted
//            input sample produces R output samples ramping linearly from
//            the previous sample to the new one; the R-th equals the input.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - moving_interp_if slave: idata/ivalid/iready in,
//                    odata/ovalid/oready out
// Params   : WIDTH  - sample width (1..64)
//            SHIFT  - log2 of the interpolation ratio (1..8)
//            SIGNED - 1: two's-complement samples, 0: unsigned samples
// Revision : 1.0 - initial release
// ============================================================================
module moving_interp
   import filt_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SHIFT  = 4,
   parameter int SIGNED = 1
) (
   input  logic            clock,
   input  logic            reset,
   moving_interp_if.slave  bus
);

   localparam int   AW       = aw_of(WIDTH, SHIFT);
   localparam logic C_SIGNED = (SIGNED != 0);

   state_t           r_state;
   state_t           w_state_next;
   logic             r_alive;
   logic [WIDTH-1:0] r_x_cur;
   logic [WIDTH-1:0] r_x_prev;

   logic             w_iready;
   logic             w_ovalid;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_k_last;
   logic             w_advance;
   logic [WIDTH-1:0] w_prev_sample;
   logic [AW-1:0]    w_ext_new;
   logic [AW-1:0]    w_ext_prev;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_in_xfer) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            // A new sample arriving on the last ramp point keeps us in RUN.
            if (w_out_xfer && w_k_last && !w_in_xfer) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_iready = 1'b0;
      w_ovalid = 1'b0;
      case (r_state)
         IDLE: begin
            w_iready = r_alive;
         end
         RUN: begin
            w_ovalid = 1'b1;
            // Accept the next sample only as the last ramp point leaves.
            w_iready = w_k_last & bus.oready;
         end
         default: begin
            w_iready = 1'b0;
            w_ovalid = 1'b0;
         end
      endcase
   end

   assign w_in_xfer  = bus.ivalid & w_iready;
   assign w_out_xfer = w_ovalid & bus.oready;
   assign w_advance  = w_out_xfer & ~w_k_last;

   assign bus.iready = w_iready;
   assign bus.ovalid = w_ovalid;

   // ------------------------------------------------------ sample history ---
   // r_alive keeps iready low until the first edge after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_alive  <= 1'b0;
         r_x_cur  <= '0;
         r_x_prev <= '0;
      end else begin
         r_alive <= 1'b1;
         if (w_in_xfer) begin
            r_x_cur <= bus.idata;
         end
         if (w_out_xfer && w_k_last) begin
            r_x_prev <= r_x_cur;
         end
      end
   end

   // When reloading from RUN the sample just finishing is still in r_x_cur
   // (r_x_prev only catches up on this same edge), so use it as the origin.
   assign w_prev_sample = (r_state == RUN) ? r_x_cur : r_x_prev;

   assign w_ext_new  = AW'(ext(EXT_MAX_W'(bus.idata), WIDTH, C_SIGNED));
   assign w_ext_prev = AW'(ext(EXT_MAX_W'(w_prev_sample), WIDTH, C_SIGNED));

   // ------------------------------------------------------------ datapath ---
   interp_ramp_acc #(
      .WIDTH  (WIDTH),
      .SHIFT  (SHIFT),
      .SIGNED (SIGNED),
      .AW     (AW)
   ) u_ramp (
      .clock    (clock),
      .reset    (reset),
      .load     (w_in_xfer),
      .advance  (w_advance),
      .ext_new  (w_ext_new),
      .ext_prev (w_ext_prev),
      .odata    (bus.odata),
      .k_last   (w_k_last)
   );

endmodule : moving_interp
`default_nettype wire
